// File: rtl/freq_div64_pkg.sv
// Shared constants, select type and select-to-counter-bit helper for freq_div64.
package freq_div64_pkg;

    localparam int CNT_W   = 15;
    localparam int PFD_BIT = 5;

    typedef logic [3:0] sel_t;

    // Select n (1..15) is served by counter bit n-1.
    function automatic logic [3:0] sel_to_bit(input sel_t sel);
        return sel - 4'd1;
    endfunction

endpackage

// File: rtl/freq_div64_counter.sv
// Free-running binary counter with asynchronous active-high clear.
module freq_div64_counter #(
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/freq_div64.sv
// Power-of-two clock divider (Fin / 2^Fsel) plus a fixed Fin/64 PFD reference.
// Define FREQDIV64_SEL_SYNC_EN to make select changes take effect only at counter wrap.
module freq_div64
    import freq_div64_pkg::*;
#(
    parameter int CNT_W   = freq_div64_pkg::CNT_W,
    parameter int PFD_BIT = freq_div64_pkg::PFD_BIT
) (
    input  logic       Fin,
    input  logic       Resetn,
    input  logic [3:0] Fsel,
    output logic       Fout,
    output logic       F_PFD
);

    logic [CNT_W-1:0] cnt;
    sel_t             sel;

    freq_div64_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk (Fin),
        .rst (Resetn),
        .cnt (cnt)
    );

`ifdef FREQDIV64_SEL_SYNC_EN
    sel_t sel_reg;
    logic cnt_wrap;

    // Counter is all ones, so this edge returns it to zero: a common phase for every tap.
    assign cnt_wrap = &cnt;

    always_ff @(posedge Fin or posedge Resetn) begin
        if (Resetn) begin
            sel_reg <= 4'd1;
        end else if (cnt_wrap || (sel_reg == 4'd0 && Fsel != sel_reg)) begin
            sel_reg <= Fsel;
        end
    end

    assign sel = sel_reg;
`else
    assign sel = Fsel;
`endif

    // Divide-by-1 passes Fin straight through but is held low during reset.
    always_comb begin
        Fout = 1'b0;
        if (Resetn) begin
            Fout = 1'b0;
        end else if (sel == 4'd0) begin
            Fout = Fin;
        end else begin
            Fout = cnt[sel_to_bit(sel)];
        end
    end

    assign F_PFD = cnt[PFD_BIT];

endmodule

// File: tb/tb_freq_div64.sv
// Directed bench for freq_div64: per-edge expected outputs go through a scoreboard queue.
module tb_freq_div64;

    logic       Fin = 1'b0;
    logic       Resetn;
    logic [3:0] Fsel;
    logic       Fout;
    logic       F_PFD;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    logic [3:0] msel = 4'd1;

    typedef struct {
        string tag;
        logic  fout;
        logic  pfd;
    } exp_t;

    exp_t sb[$];

    freq_div64 dut (
        .Fin    (Fin),
        .Resetn (Resetn),
        .Fsel   (Fsel),
        .Fout   (Fout),
        .F_PFD  (F_PFD)
    );

    always #5 Fin = ~Fin;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Resetn = 1'b1;
        edges  = 0;
        msel   = 4'd1;
    endtask

    // Advance n Fin cycles; expected levels come from edge count since reset release.
    task automatic tick(input string tag, input int n);
        exp_t e;
        int   sh;
        logic hi_exp;
        for (int i = 0; i < n; i++) begin
            @(posedge Fin);
            if (!Resetn) begin
`ifdef FREQDIV64_SEL_SYNC_EN
                if ((edges % 32768) == 32767 || (msel == 4'd0 && Fsel != 4'd0)) msel = Fsel;
`else
                msel = Fsel;
`endif
                edges++;
            end
            sh    = int'(msel);
            e.tag = tag;
            if (Resetn) begin
                e.fout = 1'b0;
                e.pfd  = 1'b0;
                hi_exp = 1'b0;
            end else begin
                e.pfd = ((edges % 64) >= 32);
                if (sh == 0) begin
                    e.fout = 1'b0;
                    hi_exp = 1'b1;
                end else begin
                    e.fout = ((edges % (1 << sh)) >= (1 << (sh - 1)));
                    hi_exp = e.fout;
                end
            end
            sb.push_back(e);
            #1;
            check({tag, "_fout_hi"}, Fout, hi_exp);
            @(negedge Fin);
            e = sb.pop_front();
            check({e.tag, "_fout"}, Fout, e.fout);
            check({e.tag, "_pfd"}, F_PFD, e.pfd);
        end
        $display("step %s: %0d cycles Fsel=%0d edges=%0d errors=%0d", tag, n, Fsel, edges, errors);
    endtask

    initial begin
        Resetn = 1'b1;
        Fsel   = 4'd1;
        #2;
        check("rst_fout", Fout, 1'b0);
        check("rst_pfd", F_PFD, 1'b0);
        #4;
        Resetn = 1'b0;

        tick("div2", 40);
        Fsel = 4'd5;
        tick("div32", 100);
        Fsel = 4'd12;
        tick("div4096", 6000);

        for (int s = 0; s < 16; s++) begin
            Fsel = 4'(s);
            tick($sformatf("pfd_sel%0d", s), 70);
        end

        Fsel = 4'd0;
        tick("fsel0", 20);

        // Reset asserted between edges must clear outputs without waiting for Fin.
        do_reset();
        Fsel = 4'd5;
        #2;
        Resetn = 1'b0;
        tick("mid", 48);
        #2;
        do_reset();
        #1;
        check("async_clr_fout", Fout, 1'b0);
        check("async_clr_pfd", F_PFD, 1'b0);
        Fsel = 4'd0;
        tick("rst_hold", 3);
        Fsel = 4'd5;
        #2;
        Resetn = 1'b0;
        tick("restart", 40);

        do_reset();
        Fsel = 4'd15;
        #2;
        Resetn = 1'b0;
        tick("div32768", 32800);

`ifdef FREQDIV64_SEL_SYNC_EN
        do_reset();
        Fsel = 4'd1;
        #2;
        Resetn = 1'b0;
        tick("sync_div2", 100);
        Fsel = 4'd5;
        tick("sync_to_div32", 32768);
`endif

        check("sb_empty", (sb.size() == 0), 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_div64.md
Name: freq_div64

Overview:
- Programmable power-of-two clock divider for the impedance-measurement PLL/counter path.
- Divides input clock Fin by 2^Fsel (1 to 32768) onto Fout.
- Also provides a fixed Fin/64 reference clock F_PFD for the phase-frequency detector.
- Single clock domain (Fin); all outputs derive from one free-running binary counter.

Parameters:
- CNT_W, 15, counter width; supports Fsel up to 15 (divide by 32768).
- PFD_BIT, 5, counter bit driving F_PFD (Fin/64).

Ports:
- Fin  input  1  clock; all state updates on rising edge.
- Resetn  input  1  asynchronous, active-high reset. The historical name is kept; 1 = reset asserted.
- Fsel  input  4  divide select; Fout = Fin / 2^Fsel.
- Fout  output  1  divided clock, 50% duty for Fsel>=1.
- F_PFD  output  1  Fin/64, 50% duty, independent of Fsel.

Behaviour:
- Counter cnt[CNT_W-1:0]:
  - Cleared to 0 asynchronously while Resetn=1.
  - Otherwise cnt <= cnt+1 on each Fin rising edge.
  - Wraps 0x7FFF -> 0 with no side effects.
- Bit cnt[k] toggles every 2^k edges, so its period is 2^(k+1) Fin periods.
- Fsel decode (effective select "sel"; see Optional Feature):
  - sel=0: Fout = Fin, a combinational pass-through (divide by 1).
  - sel=n with 1..15: Fout = cnt[n-1], giving period 2^n Fin periods and 50% duty.
- F_PFD = cnt[PFD_BIT]:
  - Period 64 Fin periods.
  - First rising edge occurs on the 32nd Fin rising edge after reset release.
- Reset values:
  - cnt=0, Fout=0 and F_PFD=0 while Resetn=1.
  - During reset Fout is forced 0 even for sel=0; the pass-through is gated by reset.
- Latency: for sel=n>=1, the first Fout rising edge follows the 2^(n-1)-th Fin rising edge after reset release.
- Fsel change mid-operation, macro absent:
  - The mux switches immediately (combinational).
  - The counter is not reset.
  - Fout may emit one runt pulse at the switch; this is accepted.
- Reset mid-operation: the counter and outputs clear immediately, asynchronously. Counting resumes from 0 on the first Fin edge after deassertion.
- No handshakes. Fsel is treated as quasi-static configuration.

Optional Feature:
- Macro: FREQDIV64_SEL_SYNC_EN.
- Defined:
  - A 4-bit register sel_q holds the effective select; reset value 4'd1 (divide by 2).
  - sel_q loads Fsel on the Fin rising edge at which cnt wraps to all-zeros, or when sel_q=0 and Fsel differs.
  - Gives glitch-free switching at a common phase.
  - Switch latency is up to 2^CNT_W Fin cycles.
- Undefined: sel = Fsel directly, as described in Behaviour.
- F_PFD is unaffected in both cases.

Decomposition:
- Package freq_div64_pkg:
  - CNT_W and PFD_BIT constants.
  - A typedef for the 4-bit select.
  - A function sel_to_bit(sel) returning n-1.
- One natural sub-module: freq_div64_counter, the resettable free-running counter.
- The top holds the mux, reset gating and the optional sel register.

Test Plan:
- Reset: Fin period 10 ns, Resetn=1 for 6 ns with Fsel=4'b0001 -> Fout=0, F_PFD=0 throughout reset.
- Divide by 2: release reset with Fsel=4'b0001 -> Fout period 20 ns, 50% duty, first rise at the first Fin rising edge.
- Divide by 32: Fsel=4'b0101 -> Fout period 320 ns, high 160 ns. With the macro absent, the switch is immediate.
- Divide by 4096: Fsel=4'b1100 held 60 us -> Fout period 40.96 us, 50% duty.
- F_PFD: under all Fsel values -> period 640 ns, first rise on the 32nd Fin edge after reset.
- Edge cases:
  - Fsel=0 -> Fout tracks Fin.
  - Fsel=15 -> period 327.68 us.
  - Reset asserted mid-count -> immediate clear and restart.
  - With FREQDIV64_SEL_SYNC_EN: a change 2->32 takes effect only at cnt wrap.
